// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude compare sequencer: walks two latched operands MSB first
// through one shared external 1-bit comparator slice and stops at the first difference.
module serial_comp_ctrl #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [SW-1:0]    steps
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);
  localparam logic [SW-1:0] WIDTH_S = SW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             eq_flag;
  logic             accept;

  // A slice reporting no flag at all is read as equal.
  assign eq_flag = cmp_eq | ~(cmp_gt | cmp_lt);
  assign accept  = start && (state == IDLE || state == DONE);

  assign cmp_a = (state == RUN) ? a_q[idx] : 1'b0;
  assign cmp_b = (state == RUN) ? b_q[idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= IDX_MSB;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      steps <= '0;
    end else if (accept) begin
      state <= RUN;
      idx   <= IDX_MSB;
      a_q   <= a;
      b_q   <= b;
      busy  <= 1'b1;
      done  <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      steps <= '0;
    end else begin
      case (state)
        RUN: begin
          // Priority gt > lt > eq; the first differing bit decides.
          if (cmp_gt) begin
            gt    <= 1'b1;
            steps <= WIDTH_S - SW'(idx);
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cmp_lt) begin
            lt    <= 1'b1;
            steps <= WIDTH_S - SW'(idx);
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (eq_flag && idx == '0) begin
            eq    <= 1'b1;
            steps <= WIDTH_S;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (eq_flag) begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
